// File: rtl/axis_sum_decimator_pkg.sv
// rtl/axis_sum_decimator_pkg.sv - shared constants, state type and width helpers for the decimator
package axis_sum_decimator_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_DECIMATION = 8;

    typedef enum logic {
        ACCUMULATE     = 1'b0,
        OUTPUT_PENDING = 1'b1
    } dec_state_t;

    function automatic int log2_ceil(input int value);
        return $clog2(value);
    endfunction

    // Result width: averaging brings the sum back to sample width.
    function automatic int out_width(input int data_width, input int decimation, input int average);
        return (average != 0) ? data_width : data_width + log2_ceil(decimation);
    endfunction

endpackage

// File: rtl/axis_sum_decimator_if.sv
// rtl/axis_sum_decimator_if.sv - valid/ready sample stream bundle with master/slave views
interface axis_sum_decimator_if #(
    parameter int W = 16
) ();

    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_sum_decimator.sv
// rtl/axis_sum_decimator.sv - sums (or averages) each window of DECIMATION signed samples
module axis_sum_decimator
    import axis_sum_decimator_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DECIMATION = DEFAULT_DECIMATION,
    parameter int AVERAGE    = 1,
    localparam int CNT_WIDTH = log2_ceil(DECIMATION),
    localparam int ACC_WIDTH = DATA_WIDTH + CNT_WIDTH,
    localparam int OUT_WIDTH = out_width(DATA_WIDTH, DECIMATION, AVERAGE)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clear_i,
    axis_sum_decimator_if.slave    s_axis,
    axis_sum_decimator_if.master   m_axis,
    output logic [CNT_WIDTH-1:0]   window_count_o
);

    localparam int SHIFT = (AVERAGE != 0) ? CNT_WIDTH : 0;

    dec_state_t                    state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;

    logic signed [DATA_WIDTH-1:0]  in_sample;
    logic signed [ACC_WIDTH-1:0]   sum_full;
    logic [OUT_WIDTH-1:0]          result;
    logic                          in_ready;
    logic                          in_beat;
    logic                          last_beat;
    logic                          window_done;
    logic                          out_beat;

    assign in_sample   = s_axis.tdata;
    assign sum_full    = acc_q + ACC_WIDTH'(in_sample);
    // Arithmetic shift floors toward -inf; no rounding term is added.
    assign result      = OUT_WIDTH'(sum_full >>> SHIFT);

    assign in_ready    = !out_valid_q || m_axis.tready;
    assign in_beat     = s_axis.tvalid && in_ready && !clear_i;
    assign last_beat   = (cnt_q == CNT_WIDTH'(DECIMATION - 1));
    assign window_done = in_beat && last_beat;
    assign out_beat    = out_valid_q && m_axis.tready;

    assign s_axis.tready  = in_ready;
    assign m_axis.tdata   = out_data_q;
    assign m_axis.tvalid  = out_valid_q;
    assign window_count_o = cnt_q;

    // Clear wins over a same-cycle input beat; in_beat already excludes it.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_beat) begin
            if (last_beat) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_full;
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ACCUMULATE: begin
                if (window_done) begin
                    state_d     = OUTPUT_PENDING;
                    out_valid_d = 1'b1;
                    out_data_d  = result;
                end
            end
            OUTPUT_PENDING: begin
                // A completing window in the accept cycle reloads the result back-to-back.
                if (window_done) begin
                    out_data_d = result;
                end else if (out_beat) begin
                    state_d     = ACCUMULATE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ACCUMULATE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ACCUMULATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
